// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU front end: opcode prefixes, register
// write-enable bit positions, data_bus source codes and the sequencer FSM states.
package cpu_pkg;

    // Opcode prefixes, compared against the top bits of the instruction
    localparam logic       OP_LOAD = 1'b0;      // 0ddd_nnnn
    localparam logic [1:0] OP_MOVE = 2'b10;     // 10dd_dsss
    localparam logic [2:0] OP_ALU  = 3'b110;    // 110x_yfff
    localparam logic [3:0] OP_JMP  = 4'b1110;   // 1110_aaaa
    localparam logic [3:0] OP_JNZ  = 4'b1111;   // 1111_aaaa

    localparam logic [3:0] REG_X0   = 4'd0;
    localparam logic [3:0] REG_X1   = 4'd1;
    localparam logic [3:0] REG_Y0   = 4'd2;
    localparam logic [3:0] REG_Y1   = 4'd3;
    localparam logic [3:0] REG_R    = 4'd4;
    localparam logic [3:0] REG_M    = 4'd5;
    localparam logic [3:0] REG_I    = 4'd6;
    localparam logic [3:0] REG_DM   = 4'd7;
    localparam logic [3:0] REG_OREG = 4'd8;

    // Destination field encoding used by load and move
    localparam logic [2:0] DEST_I  = 3'd6;
    localparam logic [2:0] DEST_DM = 3'd7;

    localparam logic [3:0] SRC_X0      = 4'd0;
    localparam logic [3:0] SRC_X1      = 4'd1;
    localparam logic [3:0] SRC_Y0      = 4'd2;
    localparam logic [3:0] SRC_Y1      = 4'd3;
    localparam logic [3:0] SRC_R       = 4'd4;
    localparam logic [3:0] SRC_M       = 4'd5;
    localparam logic [3:0] SRC_I       = 4'd6;
    localparam logic [3:0] SRC_DM      = 4'd7;
    localparam logic [3:0] SRC_PM_DATA = 4'd8;
    localparam logic [3:0] SRC_I_PINS  = 4'd9;
    localparam logic [3:0] SRC_ALU     = 4'd10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    // The destination field orders o_reg before m/i/dm, unlike the reg_en bit map
    function automatic logic [3:0] dest_bit(input logic [2:0] dest);
        logic [3:0] bit_idx;
        case (dest)
            3'd0:    bit_idx = REG_X0;
            3'd1:    bit_idx = REG_X1;
            3'd2:    bit_idx = REG_Y0;
            3'd3:    bit_idx = REG_Y1;
            3'd4:    bit_idx = REG_OREG;
            3'd5:    bit_idx = REG_M;
            3'd6:    bit_idx = REG_I;
            default: bit_idx = REG_DM;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Pure combinational instruction decode: ir -> bus source, write enables, i
// auto-increment and jump flags. Gating to the execute cycle is done by the parent.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       is_jump,
    output logic       is_jnz
);

    logic [2:0] dest;
    logic       has_dest;
    logic       src_is_dm;

    assign x_sel = ir[4];
    assign y_sel = ir[3];

    always_comb begin
        source_sel = SRC_X0;
        reg_en     = '0;
        i_sel      = 1'b0;
        is_jump    = 1'b0;
        is_jnz     = 1'b0;
        dest       = '0;
        has_dest   = 1'b0;
        src_is_dm  = 1'b0;

        if (ir[7] == OP_LOAD) begin
            dest       = ir[6:4];
            has_dest   = 1'b1;
            source_sel = SRC_PM_DATA;
        end else if (ir[7:6] == OP_MOVE) begin
            dest       = ir[5:3];
            has_dest   = 1'b1;
            src_is_dm  = (ir[2:0] == DEST_DM);
            // A register moved onto itself is the encoding for reading the input pins
            source_sel = (ir[5:3] == ir[2:0]) ? SRC_I_PINS : {1'b0, ir[2:0]};
        end else if (ir[7:5] == OP_ALU) begin
            reg_en[REG_R] = 1'b1;
            source_sel    = SRC_ALU;
        end else if (ir[7:4] == OP_JMP) begin
            is_jump = 1'b1;
        end else begin
            is_jnz = 1'b1;
        end

        if (has_dest) begin
            reg_en[dest_bit(dest)] = 1'b1;
            // Any dm access post-increments i, unless i itself is being written
            if ((dest == DEST_DM || src_is_dm) && dest != DEST_I) begin
                reg_en[REG_I] = 1'b1;
                i_sel         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions from program ROM over req/ack, decodes them
// and drives the computational unit. Optional ROM watchdog: PROGRAM_SEQUENCER_WATCHDOG_EN.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int              ROM_TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic            rom_ack,
    input  logic [7:0]      rom_data,
    input  logic            r_eq_0,
    output logic            sync_reset,
    output logic [3:0]      source_sel,
    output logic [3:0]      nibble_ir,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            rom_err
);

    state_t          state;
    state_t          state_next;
    logic [8:0]      dec_reg_en;
    logic            dec_i_sel;
    logic            dec_jump;
    logic            dec_jnz;
    logic            jump_taken;
    logic [PC_W-1:0] next_pc;

    instruction_decoder u_decoder (
        .ir         (ir),
        .source_sel (source_sel),
        .reg_en     (dec_reg_en),
        .i_sel      (dec_i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .is_jump    (dec_jump),
        .is_jnz     (dec_jnz)
    );

    assign rom_addr  = pc;
    assign nibble_ir = ir[3:0];

    // Jumps only replace the low nibble, so targets stay within the current 16-byte page
    assign jump_taken = dec_jump || (dec_jnz && !r_eq_0);
    assign next_pc    = jump_taken ? {pc[PC_W-1:4], ir[3:0]} : pc + PC_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_VECTOR;
            ir <= 8'hFF;
        end else begin
            if (state == ST_FETCH && rom_ack) begin
                ir <= rom_data;
            end
            if (state == ST_EXEC) begin
                pc <= next_pc;
            end
        end
    end

`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
    localparam int WD_W = $clog2(ROM_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            rom_err_q;

    assign wd_expired = (state == ST_FETCH) && !rom_ack && (wd_cnt == WD_W'(ROM_TIMEOUT - 1));

    // Counts cycles spent waiting in FETCH; restarts from zero on every FETCH entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= '0;
            rom_err_q <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (wd_expired) begin
                rom_err_q <= 1'b1;
            end
        end
    end

    assign rom_err = rom_err_q;
`else
    localparam int unused_rom_timeout = ROM_TIMEOUT;

    assign rom_err = 1'b0;
`endif

    // Outputs come straight from the state so reset removes rom_req asynchronously
    always_comb begin
        state_next = state;
        sync_reset = 1'b0;
        rom_req    = 1'b0;
        reg_en     = '0;
        i_sel      = 1'b0;

        case (state)
            ST_INIT: begin
                sync_reset = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    state_next = ST_EXEC;
                end
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
                else if (wd_expired) begin
                    state_next = ST_HALT;
                end
`endif
            end
            ST_EXEC: begin
                reg_en     = dec_reg_en;
                i_sel      = dec_i_sel;
                state_next = ST_FETCH;
            end
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
            ST_HALT: begin
                state_next = ST_HALT;
            end
`endif
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/decode/sequencing front end for the 4-bit microprocessor.
- Fetches 8-bit instructions from slow program ROM over a req/ack handshake and decodes them.
- Drives the computational unit's control inputs (source_sel, reg_en, i_sel, x_sel, y_sel, nibble_ir, sync_reset) and consumes its r_eq_0 flag for conditional jumps.
- Owns the program counter.

Parameters:
- PC_W, 8: program counter / ROM address width.
- RESET_VECTOR, 8'h00: PC value after reset.
- ROM_TIMEOUT, 16: maximum wait cycles for rom_ack. Used only with the watchdog feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rom_req  out  1  fetch request, held until ack.
- rom_addr  out  PC_W  fetch address (= pc).
- rom_ack  in  1  ROM data valid, single-cycle pulse.
- rom_data  in  8  instruction byte, valid with rom_ack.
- r_eq_0  in  1  zero flag from the computational unit.
- sync_reset  out  1  synchronous clear to the computational unit.
- source_sel  out  4  data_bus source select.
- nibble_ir  out  4  ir[3:0] (immediate data / ALU function).
- reg_en  out  9  write enables. Bit map: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 o_reg.
- i_sel  out  1  0 = load i from bus, 1 = i += m.
- x_sel  out  1  ALU x operand select (ir[4]).
- y_sel  out  1  ALU y operand select (ir[3]).
- pc  out  PC_W  current program counter.
- ir  out  8  current instruction register.
- rom_err  out  1  sticky watchdog error. Tied 0 when the watchdog is compiled out.

Behaviour:
- Reset (reset_n low, async):
  - state=INIT, pc=RESET_VECTOR, ir=8'hFF, rom_req=0, rom_err=0, sync_reset=1, reg_en=0.
- FSM states: INIT -> FETCH -> EXEC -> FETCH ...
  - INIT: exactly one cycle after reset release. sync_reset=1, then go to FETCH. sync_reset=0 in all other states.
  - FETCH: rom_req=1, rom_addr=pc, stay until rom_ack=1. On ack: ir<=rom_data, go to EXEC. rom_ack outside FETCH is ignored.
  - EXEC: exactly one cycle. reg_en is the decoded value; pc<=next_pc; go to FETCH.
- reg_en=0 in every state except EXEC.
- source_sel, x_sel, y_sel and nibble_ir decode combinationally from ir at all times.
- Decode:
  - Load, 0ddd_nnnn:
    - dest d (0..7 = x0,x1,y0,y1,o_reg,m,i,dm) maps to reg_en bit 0,1,2,3,8,5,6,7.
    - source_sel=8 (pm_data).
  - Move, 10dd_dsss:
    - dest as Load; source_sel = sss (0..7 = x0,x1,y0,y1,r,m,i,dm).
    - If ddd==sss, source_sel=9 (i_pins) instead.
  - ALU, 110x_yfff: reg_en[4]=1, x_sel=x, y_sel=y, source_sel=10.
  - Jump, 1110_aaaa: next_pc={pc[PC_W-1:4],aaaa}.
  - Jnz, 1111_aaaa: if r_eq_0==0, jump as above; else pc+1.
- i auto-increment:
  - Applies when dm is the load/move destination or the move source, and i is not the destination.
  - Then reg_en[6]=1 and i_sel=1 in the same EXEC cycle.
  - Otherwise i_sel=0.
- Non-jump instructions: next_pc=pc+1, modulo 2^PC_W (255 -> 0).
- r_eq_0 is sampled in the Jnz EXEC cycle. It reflects the previous ALU result, because the r update is registered.
- Reset mid-fetch: rom_req drops immediately (async). Any late rom_ack is ignored until FETCH is re-entered.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_WATCHDOG_EN.
- With the macro:
  - A counter runs in FETCH, cleared on FETCH entry.
  - If ROM_TIMEOUT cycles pass without rom_ack: rom_err<=1 (sticky until reset), rom_req<=0, FSM enters HALT.
  - HALT holds with reg_en=0 and exits only on reset.
- Without the macro: no counter, no HALT state, rom_err tied 0, FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode field constants: LOAD, MOVE, ALU, JMP, JNZ prefixes;
  - reg_en bit indices;
  - source_sel codes 0..10;
  - FSM state enum.
- One sub-module, instruction_decoder: pure combinational ir -> source_sel/reg_en/i_sel/x_sel/y_sel/jump flags. Gating by EXEC stays in the parent.

Test Plan:
- Reset release with rom_ack tied to a 3-cycle-latency model -> sync_reset high one cycle; first rom_addr=0x00; rom_req held 3 cycles; no reg_en pulse before the first EXEC.
- Fetch 0x25 (load x1... d=2 -> y0, data 5) -> in EXEC: reg_en=9'h004, source_sel=8, nibble_ir=5; pc 0x00 -> 0x01.
- Fetch 0xBF (move dm->dm) then 0x87 (move x0<-dm) -> 0xBF: source_sel=9, reg_en bits 7 and 6 set, i_sel=1. 0x87: source_sel=7, reg_en bits 0 and 6, i_sel=1.
- pc=0x3A, fetch 0xF4 with r_eq_0=0 -> next pc=0x34. Repeat with r_eq_0=1 -> next pc=0x3B.
- pc=0xFF, fetch 0xD2 (ALU add x1,y0) -> reg_en=9'h010, x_sel=1, y_sel=0; pc wraps to 0x00.
- Watchdog build, rom_ack never asserted -> after 16 cycles rom_err=1, rom_req=0, no further reg_en. Then assert reset_n low -> rom_err clears, pc=0.
